// File: rtl/seg7_pkg.sv
// Glyph table, state encoding and ASCII-to-segment decoder shared by the scroller.
package seg7_pkg;

  // Segment bit positions within {dp,g,f,e,d,c,b,a}.
  localparam int unsigned SEG_BIT_A  = 0;
  localparam int unsigned SEG_BIT_B  = 1;
  localparam int unsigned SEG_BIT_C  = 2;
  localparam int unsigned SEG_BIT_D  = 3;
  localparam int unsigned SEG_BIT_E  = 4;
  localparam int unsigned SEG_BIT_F  = 5;
  localparam int unsigned SEG_BIT_G  = 6;
  localparam int unsigned SEG_BIT_DP = 7;

  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;

  localparam logic [7:0] SEG_A = 8'h77;
  localparam logic [7:0] SEG_B = 8'h7C;
  localparam logic [7:0] SEG_C = 8'h39;
  localparam logic [7:0] SEG_D = 8'h5E;
  localparam logic [7:0] SEG_E = 8'h79;
  localparam logic [7:0] SEG_F = 8'h71;
  localparam logic [7:0] SEG_G = 8'h3D;
  localparam logic [7:0] SEG_H = 8'h76;
  localparam logic [7:0] SEG_I = 8'h30;
  localparam logic [7:0] SEG_J = 8'h1E;
  localparam logic [7:0] SEG_K = 8'h75;
  localparam logic [7:0] SEG_L = 8'h38;
  localparam logic [7:0] SEG_M = 8'h37;
  localparam logic [7:0] SEG_N = 8'h54;
  localparam logic [7:0] SEG_O = 8'h3F;
  localparam logic [7:0] SEG_P = 8'h73;
  localparam logic [7:0] SEG_Q = 8'h67;
  localparam logic [7:0] SEG_R = 8'h50;
  localparam logic [7:0] SEG_S = 8'h6D;
  localparam logic [7:0] SEG_T = 8'h78;
  localparam logic [7:0] SEG_U = 8'h3E;
  localparam logic [7:0] SEG_V = 8'h1C;
  localparam logic [7:0] SEG_W = 8'h2A;
  localparam logic [7:0] SEG_X = 8'h49;
  localparam logic [7:0] SEG_Y = 8'h6E;
  localparam logic [7:0] SEG_Z = 8'h5B;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  // Decimal point alone marks a code with no glyph.
  localparam logic [7:0] SEG_ERR   = 8'h80;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StShow = 2'd1,
    StGap  = 2'd2
  } state_e;

  function automatic logic [7:0] seg7_digit(input logic [3:0] d);
    logic [7:0] g;
    case (d)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_ERR;
    endcase
    return g;
  endfunction

  // idx is the letter's offset from 'A' (or 'a').
  function automatic logic [7:0] seg7_letter(input logic [4:0] idx);
    logic [7:0] g;
    case (idx)
      5'd0:    g = SEG_A;
      5'd1:    g = SEG_B;
      5'd2:    g = SEG_C;
      5'd3:    g = SEG_D;
      5'd4:    g = SEG_E;
      5'd5:    g = SEG_F;
      5'd6:    g = SEG_G;
      5'd7:    g = SEG_H;
      5'd8:    g = SEG_I;
      5'd9:    g = SEG_J;
      5'd10:   g = SEG_K;
      5'd11:   g = SEG_L;
      5'd12:   g = SEG_M;
      5'd13:   g = SEG_N;
      5'd14:   g = SEG_O;
      5'd15:   g = SEG_P;
      5'd16:   g = SEG_Q;
      5'd17:   g = SEG_R;
      5'd18:   g = SEG_S;
      5'd19:   g = SEG_T;
      5'd20:   g = SEG_U;
      5'd21:   g = SEG_V;
      5'd22:   g = SEG_W;
      5'd23:   g = SEG_X;
      5'd24:   g = SEG_Y;
      5'd25:   g = SEG_Z;
      default: g = SEG_ERR;
    endcase
    return g;
  endfunction

  function automatic logic [7:0] seg7_decode(input logic [7:0] c);
    logic [7:0] off;
    logic [7:0] g;
    off = 8'h00;
    if (c >= 8'h30 && c <= 8'h39) begin
      off = c - 8'h30;
      g   = seg7_digit(off[3:0]);
    end else if (c >= 8'h41 && c <= 8'h5A) begin
      off = c - 8'h41;
      g   = seg7_letter(off[4:0]);
    end else if (c >= 8'h61 && c <= 8'h7A) begin
      off = c - 8'h61;
      g   = seg7_letter(off[4:0]);
    end else if (c == 8'h20) begin
      g = SEG_BLANK;
    end else if (c == 8'h2D) begin
      g = SEG_DASH;
    end else begin
      g = SEG_ERR;
    end
    return g;
  endfunction

endpackage

// File: rtl/char_fifo.sv
// Synchronous FIFO; extra pointer bit separates full from empty. No bypass path.
module char_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; reset flushes the queue.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/seg7_char_scroller.sv
// Buffers ASCII bytes and shows each on the 7-segment output for a hold period
// followed by a blank gap.
module seg7_char_scroller
  import seg7_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 10_000_000,
  parameter int unsigned GAP_CYCLES  = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [7:0] seg_out,
  output logic       busy
);

  localparam int unsigned MaxCycles = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned TimerW    = $clog2(MaxCycles + 1);
  localparam bit          HasGap    = (GAP_CYCLES > 0);

  typedef logic [TimerW-1:0] timer_t;

  localparam timer_t HoldLoad = timer_t'(HOLD_CYCLES - 1);
  localparam timer_t GapLoad  = timer_t'(HasGap ? GAP_CYCLES - 1 : 0);
  localparam timer_t TimerOne = timer_t'(1);

  state_e     state_q, state_d;
  timer_t     timer_q, timer_d;
  logic [7:0] seg_q, seg_d;

  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;

  char_fifo #(
    .WIDTH(8),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (char_valid),
    .data_i (char_in),
    .pop_i  (fifo_pop),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (fifo_head)
  );

  assign char_ready = !fifo_full;
  assign seg_out    = seg_q;
  assign busy       = (state_q != StIdle) || !fifo_empty;

  // Next-state logic; everything holds while en is low.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    seg_d    = seg_q;
    fifo_pop = 1'b0;
    if (en) begin
      unique case (state_q)
        StIdle: begin
          seg_d = SEG_BLANK;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            seg_d    = seg7_decode(fifo_head);
            timer_d  = HoldLoad;
            state_d  = StShow;
          end
        end
        StShow: begin
          if (timer_q == '0) begin
            if (HasGap) begin
              seg_d   = SEG_BLANK;
              timer_d = GapLoad;
              state_d = StGap;
            end else if (!fifo_empty) begin
              // Zero-length gap: chain straight into the next character.
              fifo_pop = 1'b1;
              seg_d    = seg7_decode(fifo_head);
              timer_d  = HoldLoad;
              state_d  = StShow;
            end else begin
              seg_d   = SEG_BLANK;
              state_d = StIdle;
            end
          end else begin
            timer_d = timer_q - TimerOne;
          end
        end
        StGap: begin
          seg_d = SEG_BLANK;
          if (timer_q == '0) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              seg_d    = seg7_decode(fifo_head);
              timer_d  = HoldLoad;
              state_d  = StShow;
            end else begin
              state_d = StIdle;
            end
          end else begin
            timer_d = timer_q - TimerOne;
          end
        end
        default: begin
          seg_d   = SEG_BLANK;
          timer_d = '0;
          state_d = StIdle;
        end
      endcase
    end
  end

  // State, timer and display registers; reset aborts any character in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      timer_q <= '0;
      seg_q   <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      seg_q   <= seg_d;
    end
  end

endmodule
